cpu_controller: RTL

Multicycle controller that issues operations to the datapath ALU and register file. It latches a 16-bit instruction, decodes it, and sequences register reads, the ALU operation, status capture and register write-back, one control step per clock. It is the initiator side of the ALU interface: it drives the operand-select, ALU-op and load strobes that the datapath and ALU consume.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/cpu_decoder.sv | 41 ++++
 rtl/cpu_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle CPU controller.
package cpu_pkg;

  localparam int unsigned IR_W     = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned SH_W     = 2;
  localparam int unsigned VSEL_W   = 2;
  localparam int unsigned IMM8_W   = 8;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;

  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

  localparam logic [VSEL_W-1:0] VSEL_C   = 2'b00;
  localparam logic [VSEL_W-1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decode: field extraction, class flags and sign-extended im8.
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned K = 16
) (
  input  logic [IR_W-1:0]   ir_i,
  output logic [OP_W-1:0]   op_o,
  output logic [REG_AW-1:0] rn_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [SH_W-1:0]   sh_o,
  output logic [REG_AW-1:0] rm_o,
  output logic              mov_imm_o,
  output logic              mov_reg_o,
  output logic              alu_class_o,
  output logic              is_cmp_o,
  output logic              invalid_o,
  output logic [K-1:0]      sximm8_o
);

  logic [OPC_W-1:0]  opcode;
  logic [IMM8_W-1:0] im8;

  assign opcode = ir_i[15:13];
  assign op_o   = ir_i[12:11];
  assign rn_o   = ir_i[10:8];
  assign rd_o   = ir_i[7:5];
  assign sh_o   = ir_i[4:3];
  assign rm_o   = ir_i[2:0];
  assign im8    = ir_i[7:0];

  assign mov_imm_o   = (opcode == OPC_MOV) && (op_o == OP_MOV_IMM);
  assign mov_reg_o   = (opcode == OPC_MOV) && (op_o == OP_MOV_REG);
  assign alu_class_o = (opcode == OPC_ALU);
  assign is_cmp_o    = alu_class_o && (op_o == ALU_SUB);
  assign invalid_o   = !(mov_imm_o || mov_reg_o || alu_class_o);

  // Signed cast widens by replicating im8[7].
  assign sximm8_o = K'($signed(im8));

endmodule

// File: rtl/cpu_controller.sv
// Multicycle controller: latches an instruction and sequences datapath/ALU control one step per clock.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned k = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [IR_W-1:0]   in,
  output logic              w,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [VSEL_W-1:0] vsel,
  output logic [SH_W-1:0]   shift,
  output logic [OP_W-1:0]   aluop,
  output logic [k-1:0]      sximm8
);

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rn, rd, rm;
  logic [SH_W-1:0]   sh;
  logic              mov_imm, mov_reg, alu_class, is_cmp, invalid;

  cpu_decoder #(.K(k)) u_dec (
    .ir_i        (ir_q),
    .op_o        (op),
    .rn_o        (rn),
    .rd_o        (rd),
    .sh_o        (sh),
    .rm_o        (rm),
    .mov_imm_o   (mov_imm),
    .mov_reg_o   (mov_reg),
    .alu_class_o (alu_class),
    .is_cmp_o    (is_cmp),
    .invalid_o   (invalid),
    .sximm8_o    (sximm8)
  );

  // IR only accepts a new word while idle; the same edge may also start decode.
  assign ir_d = ((state_q == S_WAIT) && load) ? in : ir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    shift    = '0;
    aluop    = ALU_ADD;

    unique case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (invalid)      state_d = S_WAIT;
        else if (mov_imm) state_d = S_WRITE_IMM;
        else if (mov_reg) state_d = S_GET_B;
        else if (alu_class) state_d = S_GET_A;
        else              state_d = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
        state_d = S_ALU;
      end
      S_ALU: begin
        // MOV reg passes shifted Rm through as 0 + B; CMP only updates status.
        shift   = sh;
        asel    = mov_reg;
        aluop   = mov_reg ? ALU_ADD : op;
        loadc   = !is_cmp;
        loads   = is_cmp;
        state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        vsel     = VSEL_IMM;
        writenum = rn;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
